// File: rtl/picorv32_mem_arbiter.sv
// Two-master / one-slave arbiter for the picorv32 native memory bus.
// Grants are held until completion, abort or a bounded-wait timeout.
module picorv32_mem_arbiter #(
   parameter int          PRIO_MODE      = 0,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_WORD       = 32'hDEAD_BEEF,
   parameter int          CNT_W          = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             m0_valid,
   input  logic             m0_instr,
   input  logic [31:0]      m0_addr,
   input  logic [31:0]      m0_wdata,
   input  logic [3:0]       m0_wstrb,
   output logic             m0_ready,
   output logic [31:0]      m0_rdata,
   input  logic             m1_valid,
   input  logic             m1_instr,
   input  logic [31:0]      m1_addr,
   input  logic [31:0]      m1_wdata,
   input  logic [3:0]       m1_wstrb,
   output logic             m1_ready,
   output logic [31:0]      m1_rdata,
   output logic             s_valid,
   output logic             s_instr,
   output logic [31:0]      s_addr,
   output logic [31:0]      s_wdata,
   output logic [3:0]       s_wstrb,
   input  logic             s_ready,
   input  logic [31:0]      s_rdata,
   output logic [1:0]       grant,
   output logic             timeout_pulse,
   output logic [CNT_W-1:0] timeout_count
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   state_t           w_next;
   logic             r_last_owner;
   logic [15:0]      r_wait_cnt;
   logic             r_timeout_pulse;
   logic [CNT_W-1:0] r_timeout_count;

   logic w_own0;
   logic w_own1;
   logic w_expire;
   logic w_done;

   assign w_own0 = (r_state == OWN0);
   assign w_own1 = (r_state == OWN1);

   always_comb begin
      s_valid = 1'b0;
      s_instr = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      case (r_state)
         OWN0: begin
            s_valid = m0_valid;
            s_instr = m0_instr;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
         end
         OWN1: begin
            s_valid = m1_valid;
            s_instr = m1_instr;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
         end
         default: ;
      endcase
   end

   // s_ready on the expiry cycle wins: it is a normal completion, not a timeout.
   assign w_expire = s_valid && !s_ready && (r_wait_cnt == LP_LAST);
   assign w_done   = s_valid && (s_ready || w_expire);

   assign m0_ready = w_own0 && w_done;
   assign m1_ready = w_own1 && w_done;
   assign m0_rdata = w_own0 ? (w_expire ? ERR_WORD : s_rdata) : 32'h0;
   assign m1_rdata = w_own1 ? (w_expire ? ERR_WORD : s_rdata) : 32'h0;

   assign grant         = {w_own1, w_own0};
   assign timeout_pulse = r_timeout_pulse;
   assign timeout_count = r_timeout_count;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (m0_valid && m1_valid)
               w_next = ((PRIO_MODE == 1) || r_last_owner) ? OWN0 : OWN1;
            else if (m0_valid)
               w_next = OWN0;
            else if (m1_valid)
               w_next = OWN1;
         end
         default: begin
            // owner dropping valid (abort) or any completion releases the bus
            if (!s_valid || w_done)
               w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state         <= IDLE;
         r_last_owner    <= 1'b1;
         r_wait_cnt      <= '0;
         r_timeout_pulse <= 1'b0;
         r_timeout_count <= '0;
      end else begin
         r_state         <= w_next;
         r_timeout_pulse <= w_expire;
         if (r_state == IDLE)
            r_wait_cnt <= '0;
         else if (!s_ready)
            r_wait_cnt <= r_wait_cnt + 16'd1;
         if (w_done)
            r_last_owner <= w_own1;
         if (w_expire && (r_timeout_count != {CNT_W{1'b1}}))
            r_timeout_count <= r_timeout_count + 1'b1;
      end
   end

endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
Two-master, one-slave arbiter for the picorv32 native memory interface (valid/ready, addr/wdata/wstrb/rdata, instr). Master 0 is the soft-core CPU; master 1 is the host-side loader/trace port that preloads program memory and reads result buffers. The slave is the shared program/data memory. It adds round-robin or fixed-priority arbitration, grant hold until completion, and a bus timeout, so a stalled memory cannot hang a measurement run.

Parameters:
PRIO_MODE, 0, 0 = round-robin between m0/m1; 1 = fixed priority, m0 always wins.
TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for s_ready before forced completion; range 2..65535.
ERR_WORD, 32'hDEAD_BEEF, rdata returned to the master on a timed-out transaction.
CNT_W, 16, width of the timeout event counter.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-low reset
m0_valid  in  1  CPU request
m0_instr  in  1  CPU fetch flag
m0_addr  in  32  CPU address
m0_wdata  in  32  CPU write data
m0_wstrb  in  4  CPU byte strobes (0 = read)
m0_ready  out  1  CPU completion
m0_rdata  out  32  CPU read data
m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb  in  1/1/32/32/4  host request, same meaning as m0
m1_ready  out  1  host completion
m1_rdata  out  32  host read data
s_valid  out  1  request to memory
s_instr  out  1  forwarded instr flag
s_addr  out  32  forwarded address
s_wdata  out  32  forwarded write data
s_wstrb  out  4  forwarded strobes
s_ready  in  1  memory completion
s_rdata  in  32  memory read data
grant  out  2  one-hot current owner, 00 = idle
timeout_pulse  out  1  one-cycle registered flag after a forced completion
timeout_count  out  CNT_W  saturating count of timeouts

Behaviour:
- Reset (resetn low, async): FSM IDLE, grant=00, s_valid=0, m0_ready=m1_ready=0, wait counter=0, last_owner=m1 (so m0 wins first tie), timeout_pulse=0, timeout_count=0. Reset mid-transaction aborts immediately; s_valid drops asynchronously.
- FSM states: IDLE, OWN0, OWN1. grant is the registered state decode.
- IDLE: sample m0_valid/m1_valid. Only one valid: go to its OWNx. Both valid: PRIO_MODE=1 picks m0; PRIO_MODE=0 picks the master that is not last_owner. Neither: stay. No slave request is issued in IDLE.
- OWNx: s_valid=mx_valid; s_addr/s_wdata/s_wstrb/s_instr=mx fields (combinational mux on grant). mx_ready=s_ready, mx_rdata=s_rdata. Non-owner ready=0 and rdata=0. In IDLE, s_* data outputs are 0.
- Latency: request seen at edge N enters OWNx at N+1; s_valid high in cycle N+1. Minimum 1-cycle arbitration bubble; back-to-back transactions from one master have 1 idle cycle between completions.
- Completion: in OWNx with s_ready=1, set last_owner=x and return to IDLE next edge.
- Abort: owner drops mx_valid before s_ready. Return to IDLE next edge with no ready pulse; no counter change.
- Timeout: wait counter clears on entry to OWNx and increments each OWNx cycle without s_ready. In the cycle the counter equals TIMEOUT_CYCLES-1 with s_ready=0: mx_ready=1, mx_rdata=ERR_WORD, s_valid stays high that cycle, then go to IDLE. timeout_pulse=1 in the following cycle. timeout_count increments and saturates at all-ones.
- s_ready in the same cycle as timeout expiry is a normal completion: s_rdata is passed, with no pulse and no count.
- A write is not retried after a timeout; the master sees it as complete.
- s_ready while IDLE is ignored.

Test Plan:
- Single CPU read: m0_valid, addr 0x100; memory returns 0x12345678 with 2-cycle latency. Expect s_valid at cycle+1, m0_ready with rdata 0x12345678, grant 01 then 00.
- Tie, PRIO_MODE=0: m0 and m1 valid continuously, memory ready in 1 cycle. Expect grants alternating 01,10,01,10 starting with m0, and each master completing every 4 cycles.
- Tie, PRIO_MODE=1: same stimulus. Expect m0 to get every grant and m1_ready never to assert while m0_valid is held.
- Timeout, TIMEOUT_CYCLES=4: m1 write with s_ready held 0. Expect m1_ready with rdata 0xDEADBEEF on the 4th OWN1 cycle, timeout_pulse the next cycle, timeout_count=1.
- Boundary: s_ready arrives exactly on the expiry cycle. Expect s_rdata passed, timeout_pulse=0, count unchanged. Also force the count to all-ones and time out again; expect the count to stay at all-ones.
- Abort/reset: m0 drops valid in OWN0 before s_ready, expect IDLE next cycle with no ready. Assert resetn low mid-OWN1, expect s_valid=0 and grant=00 immediately, without a clock edge.
